// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: shares one single-port block RAM between a fetch read port (0) and a data read/write port (1)
module ram_access_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_addr0,
    output logic              o_ack0,
    output logic [DATA_W-1:0] o_rdata0,
    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic              o_busy,
    output logic              o_grant
);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_grant, w_grant_nxt;
    logic              r_wr, w_wr_nxt;
    logic              r_en, w_en_nxt;
    logic              r_we, w_we_nxt;
    logic              r_ack0, w_ack0_nxt;
    logic              r_ack1, w_ack1_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_din, w_din_nxt;
    logic [DATA_W-1:0] r_rdata0, w_rdata0_nxt;
    logic [DATA_W-1:0] r_rdata1, w_rdata1_nxt;
    logic [SC_W-1:0]   r_starve, w_starve_nxt;
    logic [LAT_W-1:0]  r_lat, w_lat_nxt;
    logic              w_pick1;

    // data port wins unless fetch has already waited through STARVE_LIMIT data grants
    assign w_pick1 = i_req1 && !(i_req0 && r_starve == STARVE_MAX);

    // next-state and next-output logic; strobes default low, everything else holds
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_wr_nxt     = r_wr;
        w_en_nxt     = 1'b0;
        w_we_nxt     = 1'b0;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_addr_nxt   = r_addr;
        w_din_nxt    = r_din;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_starve_nxt = r_starve;
        w_lat_nxt    = r_lat;
        case (r_state)
            S_IDLE: begin
                if (i_req0 || i_req1) begin
                    w_state_nxt  = S_ACCESS;
                    w_grant_nxt  = w_pick1;
                    w_wr_nxt     = w_pick1 && i_we1;
                    w_en_nxt     = 1'b1;
                    w_we_nxt     = w_pick1 && i_we1;
                    w_addr_nxt   = w_pick1 ? i_addr1 : i_addr0;
                    w_din_nxt    = (w_pick1 && i_we1) ? i_wdata1 : '0;
                    w_starve_nxt = !w_pick1 ? '0 :
                                   (i_req0 && r_starve != STARVE_MAX) ? r_starve + 1'b1 : r_starve;
                end
            end
            S_ACCESS: begin
                w_state_nxt = r_wr ? S_ACK : S_WAIT;
                w_lat_nxt   = LAT_INIT;
                w_ack1_nxt  = r_wr;
            end
            S_WAIT: begin
                if (r_lat == '0) begin
                    w_state_nxt  = S_ACK;
                    w_ack0_nxt   = !r_grant;
                    w_ack1_nxt   = r_grant;
                    w_rdata0_nxt = r_grant ? r_rdata0 : i_ram_dout;
                    w_rdata1_nxt = r_grant ? i_ram_dout : r_rdata1;
                end else begin
                    w_lat_nxt = r_lat - 1'b1;
                end
            end
            S_ACK: w_state_nxt = S_IDLE;
        endcase
    end

    // state and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= 1'b0;
            r_wr     <= 1'b0;
            r_en     <= 1'b0;
            r_we     <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_starve <= '0;
            r_lat    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_wr     <= w_wr_nxt;
            r_en     <= w_en_nxt;
            r_we     <= w_we_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_addr   <= w_addr_nxt;
            r_din    <= w_din_nxt;
            r_rdata0 <= w_rdata0_nxt;
            r_rdata1 <= w_rdata1_nxt;
            r_starve <= w_starve_nxt;
            r_lat    <= w_lat_nxt;
        end
    end

    assign o_ack0     = r_ack0;
    assign o_ack1     = r_ack1;
    assign o_rdata0   = r_rdata0;
    assign o_rdata1   = r_rdata1;
    assign o_ram_en   = r_en;
    assign o_ram_we   = r_we;
    assign o_ram_addr = r_addr;
    assign o_ram_din  = r_din;
    assign o_busy     = r_state != S_IDLE;
    assign o_grant    = r_grant;
endmodule
